// File: rtl/sr_latch_pulse_sched_pkg.sv
// Shared definitions for the SR latch pulse scheduler.
//   state_t   : controller FSM states
//   OP_SET/OP_CLR : command operation encodings
//   max_u     : helper for counter sizing
package sr_latch_pulse_sched_pkg;

  localparam int unsigned N_DEF       = 4;
  localparam int unsigned IDX_W_DEF   = 2;
  localparam int unsigned PULSE_W_DEF = 2;
  localparam int unsigned GAP_W_DEF   = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam logic OP_SET = 1'b1;
  localparam logic OP_CLR = 1'b0;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sr_latch_pulse_sched_rr_arb2.sv
// Two-input round-robin arbiter.
//   clk, rst_n    : clock, async active-low reset (priority returns to A)
//   req_a, req_b  : requests
//   gnt_a, gnt_b  : combinational grants, one-hot or zero
module rr_arb2 (
  input  logic clk,
  input  logic rst_n,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a,
  output logic gnt_b
);

  // pri_b=1 means B wins the next contested round
  logic pri_b;

  // Priority moves only when both requesters compete
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pri_b <= 1'b0;
    end else if (req_a && req_b) begin
      pri_b <= ~pri_b;
    end
  end

  always_comb begin
    gnt_a = req_a & (~req_b | ~pri_b);
    gnt_b = req_b & (~req_a |  pri_b);
  end

endmodule

// File: rtl/sr_latch_pulse_sched.sv
// Pulse scheduler for a bank of N cross-coupled NAND SR latches shared by
// requesters A and B.
//   clk, rst_n              : clock, async active-low reset
//   a_req/a_op/a_idx/a_ack  : requester A command handshake
//   b_req/b_op/b_idx/b_ack  : requester B command handshake
//   err_clr                 : clears the sticky error
//   S_n, R_n                : active-low set/reset pulses, one bit per latch
//   Q_fb                    : latch Q feedback
//   busy, err, err_idx      : status
module sr_latch_pulse_sched
  import sr_latch_pulse_sched_pkg::*;
#(
  parameter int unsigned N       = N_DEF,
  parameter int unsigned IDX_W   = IDX_W_DEF,
  parameter int unsigned PULSE_W = PULSE_W_DEF,
  parameter int unsigned GAP_W   = GAP_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_req,
  input  logic             a_op,
  input  logic [IDX_W-1:0] a_idx,
  output logic             a_ack,
  input  logic             b_req,
  input  logic             b_op,
  input  logic [IDX_W-1:0] b_idx,
  output logic             b_ack,
  input  logic             err_clr,
  output logic [N-1:0]     S_n,
  output logic [N-1:0]     R_n,
  input  logic [N-1:0]     Q_fb,
  output logic             busy,
  output logic             err,
  output logic [IDX_W-1:0] err_idx
);

  localparam int unsigned CNT_W = $clog2(max_u(PULSE_W, GAP_W) + 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               op_q, op_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               gnt_a, gnt_b;
  logic               idle;

  logic [N-1:0]       s_n_d, r_n_d;
  logic               a_ack_d, b_ack_d, busy_d, err_d;
  logic [IDX_W-1:0]   err_idx_d;
  logic               idx_ok_d, idx_ok_q, fb_bit, chk_fire;

  assign idle = (state_q == ST_IDLE);

  // Requests only reach the arbiter while idle, so priority cannot drift when busy
  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req_a (a_req & idle),
    .req_b (b_req & idle),
    .gnt_a (gnt_a),
    .gnt_b (gnt_b)
  );

  // State register with captured command and phase counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_CLR;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic: IDLE -> PULSE (PULSE_W cycles) -> GAP (GAP_W cycles) -> IDLE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    idx_d   = idx_q;
    unique case (state_q)
      ST_IDLE: begin
        if (gnt_a || gnt_b) begin
          state_d = ST_PULSE;
          cnt_d   = CNT_W'(PULSE_W - 1);
          op_d    = gnt_a ? a_op  : b_op;
          idx_d   = gnt_a ? a_idx : b_idx;
        end
      end
      ST_PULSE: begin
        if (cnt_q == '0) begin
          state_d = ST_GAP;
          cnt_d   = CNT_W'(GAP_W - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs
  always_comb begin
    s_n_d     = '1;
    r_n_d     = '1;
    a_ack_d   = gnt_a;
    b_ack_d   = gnt_b;
    busy_d    = (state_d != ST_IDLE);
    err_d     = err;
    err_idx_d = err_idx;
    idx_ok_d  = ({1'b0, idx_d} < (IDX_W + 1)'(N));
    idx_ok_q  = ({1'b0, idx_q} < (IDX_W + 1)'(N));
    fb_bit    = 1'b0;
    chk_fire  = (state_q == ST_GAP) && (cnt_q == '0);

    // Only one of the 2N lines is ever driven low
    for (int k = 0; k < N; k++) begin
      if ((state_d == ST_PULSE) && idx_ok_d && (IDX_W'(k) == idx_d)) begin
        if (op_d == OP_SET) s_n_d[k] = 1'b0;
        if (op_d == OP_CLR) r_n_d[k] = 1'b0;
      end
      if (IDX_W'(k) == idx_q) fb_bit = Q_fb[k];
    end

    // A new error on the same edge overrides err_clr
    if (err_clr) err_d = 1'b0;
    if (chk_fire && (!idx_ok_q || (fb_bit != op_q))) begin
      err_d     = 1'b1;
      err_idx_d = idx_q;
    end
  end

  // Output registers; reset releases all latch controls immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      S_n     <= '1;
      R_n     <= '1;
      a_ack   <= 1'b0;
      b_ack   <= 1'b0;
      busy    <= 1'b0;
      err     <= 1'b0;
      err_idx <= '0;
    end else begin
      S_n     <= s_n_d;
      R_n     <= r_n_d;
      a_ack   <= a_ack_d;
      b_ack   <= b_ack_d;
      busy    <= busy_d;
      err     <= err_d;
      err_idx <= err_idx_d;
    end
  end

endmodule
